lab3_sweep_ctrl: RTL and testbench
==================================

# lab3_sweep_ctrl

Synthesizable self-test controller for the lab3 three-input, two-output combinational block (inputs a, b, c; outputs x, y). On a start pulse it drives all 8 input combinations in ascending order, waits a programmable settle time per vector, and compares x/y against a parameterised expected truth table. It then reports pass/fail, a mismatch count and the first failing vector. It sits beside the lab3 instance on the board, replacing the exhaustive simulation stimulus with an on-chip sweep.

## Interface
- SETTLE_CYC, default 2: cycles each vector is held before sampling; legal range 1..15.
- EXP_X, default 8'hE8: expected x; bit i is the expected value for vector i = {a,b,c}. The default is the full-adder carry.
- EXP_Y, default 8'h96: expected y, indexed the same way. The default is the full-adder sum.

- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- start  in  1  single-cycle request; accepted only in IDLE
- a  out  1  DUT input, vector bit 2
- b  out  1  DUT input, vector bit 1
- c  out  1  DUT input, vector bit 0
- x  in  1  DUT output
- y  in  1  DUT output
- busy  out  1  high from the cycle after start is accepted through the last CHECK
- done  out  1  one-cycle pulse at sweep end
- pass  out  1  high when the last completed sweep had zero mismatches; held until the next start
- fail_count  out  4  number of mismatching vectors in the current or last sweep (0..8)
- first_fail_vec  out  3  index of the first mismatching vector
- first_fail_valid  out  1  first_fail_vec is meaningful

## Operation
- FSM states:
  - IDLE, on start: vec=0, settle count=0, fail_count=0, first_fail_valid=0, pass=0. Go to SETTLE.
  - SETTLE: increment the count. When count reaches SETTLE_CYC-1, go to CHECK.
  - CHECK: compare {x,y} with {EXP_X[vec],EXP_Y[vec]}.
    - On mismatch: increment fail_count. If first_fail_valid=0, capture vec and set first_fail_valid.
    - If vec==7: go to DONE. Otherwise vec+1, count=0, go to SETTLE.
  - DONE: done=1, pass=(fail_count==0). Go to IDLE.
- {a,b,c} is always the registered vec value; outputs change only on the CHECK→SETTLE transition and on start.
- vec is 3 bits and never wraps mid-sweep; the sweep terminates at vec=7.
- start is ignored in SETTLE, CHECK and DONE. No queuing.
- If a mismatch and vec==7 occur together in CHECK, the count is updated before pass is evaluated in DONE.
- x/y are sampled only in CHECK. Values in SETTLE are don't-care, since the DUT is combinational with asynchronous glitches.

## Timing
- Reset values: a=b=c=0, busy=0, done=0, pass=0, fail_count=0, first_fail_vec=0, first_fail_valid=0, state IDLE.
- Per-vector cost: SETTLE_CYC+1 cycles.
- Start is accepted at edge 0. done is high in the cycle after edge 8·(SETTLE_CYC+1), which is 24 cycles with defaults.
- busy is high for exactly 8·(SETTLE_CYC+1) cycles. done is asserted the cycle busy falls.
- Reset asserted mid-sweep: all outputs take their reset values immediately (asynchronously). A new start is needed after release.
- rst_n deassertion is synchronised externally. The first edge after release may carry start.

## Configuration
- SWEEP_STOP_ON_FAIL_EN:
  - Defined: the first mismatch in CHECK goes directly to DONE. fail_count=1, first_fail_valid=1, a/b/c hold the failing vector, and pass=0.
  - Undefined: all 8 vectors are always applied and fail_count reports the total number of mismatches.

## Test plan
- Correct full-adder DUT model, defaults, start at cycle 0:
  - {a,b,c} steps 000..111, each held 3 cycles.
  - done pulses after 24 cycles; pass=1, fail_count=0, first_fail_valid=0.
- DUT with y stuck at 0 → fail_count=4, first_fail_vec=1, first_fail_valid=1, pass=0.
- Start re-pulsed at cycles 5 and 20 of a sweep → ignored; done still occurs exactly once, after 24 cycles.
- rst_n low at cycle 10 for 2 cycles → busy=0, a=b=c=0, fail_count=0 immediately. A new start gives a full 24-cycle sweep.
- SWEEP_STOP_ON_FAIL_EN defined, x inverted at vector 3 → done 12 cycles after start; {a,b,c}=011, fail_count=1, first_fail_vec=3.
- SETTLE_CYC=1 with the correct DUT → done after 16 cycles, pass=1.

Source files
------------

// File: rtl/lab3_sweep_ctrl_if.sv
// Sweep controller port bundle: start request, lab3 stimulus/response and sweep status.
// Master is the requester/board side, slave is the controller.
interface lab3_sweep_ctrl_if;
   logic       start;
   logic       a;
   logic       b;
   logic       c;
   logic       x;
   logic       y;
   logic       busy;
   logic       done;
   logic       pass;
   logic [3:0] fail_count;
   logic [2:0] first_fail_vec;
   logic       first_fail_valid;

   modport master (
      output start, x, y,
      input  a, b, c, busy, done, pass, fail_count, first_fail_vec, first_fail_valid
   );

   modport slave (
      input  start, x, y,
      output a, b, c, busy, done, pass, fail_count, first_fail_vec, first_fail_valid
   );
endinterface

// File: rtl/lab3_sweep_ctrl.sv
// On-chip exhaustive sweep of the lab3 block against EXP_X/EXP_Y; optional SWEEP_STOP_ON_FAIL_EN ends at first mismatch.
// Latency: 8*(SETTLE_CYC+1) cycles from accepted start to the done pulse (less when stopping early).
// Backpressure: none; start is only accepted in IDLE and is otherwise dropped, never queued.
module lab3_sweep_ctrl #(
   parameter int unsigned SETTLE_CYC = 2,
   parameter logic [7:0]  EXP_X      = 8'hE8,
   parameter logic [7:0]  EXP_Y      = 8'h96
) (
   input logic              clk,
   input logic              rst_n,
   lab3_sweep_ctrl_if.slave bus
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SETTLE = 2'd1,
      CHECK  = 2'd2,
      DONE   = 2'd3
   } state_t;

   localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_CYC - 1);
   localparam logic [2:0] VEC_LAST    = 3'd7;

   state_t     state;
   logic [2:0] vec;
   logic [3:0] settle_cnt;
   logic [3:0] fail_count_q;
   logic [2:0] first_fail_vec_q;
   logic       first_fail_valid_q;
   logic       busy_q;
   logic       done_q;
   logic       pass_q;

   logic       mismatch;
   logic       sweep_end;
   logic [3:0] fail_next;

   assign mismatch  = ({bus.x, bus.y} != {EXP_X[vec], EXP_Y[vec]});
   assign fail_next = fail_count_q + {3'd0, mismatch};

`ifdef SWEEP_STOP_ON_FAIL_EN
   assign sweep_end = (vec == VEC_LAST) || mismatch;
`else
   assign sweep_end = (vec == VEC_LAST);
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state              <= IDLE;
         vec                <= 3'd0;
         settle_cnt         <= 4'd0;
         fail_count_q       <= 4'd0;
         first_fail_vec_q   <= 3'd0;
         first_fail_valid_q <= 1'b0;
         busy_q             <= 1'b0;
         done_q             <= 1'b0;
         pass_q             <= 1'b0;
      end else begin
         done_q <= 1'b0;
         case (state)
            IDLE: begin
               if (bus.start) begin
                  vec                <= 3'd0;
                  settle_cnt         <= 4'd0;
                  fail_count_q       <= 4'd0;
                  first_fail_vec_q   <= 3'd0;
                  first_fail_valid_q <= 1'b0;
                  pass_q             <= 1'b0;
                  busy_q             <= 1'b1;
                  state              <= SETTLE;
               end
            end
            SETTLE: begin
               if (settle_cnt == SETTLE_LAST) begin
                  state <= CHECK;
               end else begin
                  settle_cnt <= settle_cnt + 4'd1;
               end
            end
            CHECK: begin
               if (mismatch) begin
                  fail_count_q <= fail_next;
                  if (!first_fail_valid_q) begin
                     first_fail_vec_q   <= vec;
                     first_fail_valid_q <= 1'b1;
                  end
               end
               // pass is judged on the count including this vector's result
               if (sweep_end) begin
                  busy_q <= 1'b0;
                  done_q <= 1'b1;
                  pass_q <= (fail_next == 4'd0);
                  state  <= DONE;
               end else begin
                  vec        <= vec + 3'd1;
                  settle_cnt <= 4'd0;
                  state      <= SETTLE;
               end
            end
            DONE: begin
               state <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

   assign bus.a                = vec[2];
   assign bus.b                = vec[1];
   assign bus.c                = vec[0];
   assign bus.busy             = busy_q;
   assign bus.done             = done_q;
   assign bus.pass             = pass_q;
   assign bus.fail_count       = fail_count_q;
   assign bus.first_fail_vec   = first_fail_vec_q;
   assign bus.first_fail_valid = first_fail_valid_q;

endmodule

// File: tb/tb_lab3_sweep_ctrl.sv
// Scoreboard bench for lab3_sweep_ctrl: instance 0 uses SETTLE_CYC=2, instance 1 uses SETTLE_CYC=1.
module tb_lab3_sweep_ctrl;

   typedef struct {
      int         done_cyc;
      int         busy_cyc;
      logic       pass;
      logic [3:0] fc;
      logic       ffvld;
      logic [2:0] ffvec;
      logic [2:0] abc;
   } exp_t;

   logic clk;
   logic rst_n;
   int   cyc;
   int   tests;
   int   fails;

   exp_t       sb_q[2][$];
   int         sweep_start[2];
   int         busy_cnt[2];
   logic       start_drv[2];
   int         fault_mode[2];
   logic       obs_busy[2];
   logic       obs_pass[2];

   lab3_sweep_ctrl_if bus[2] ();

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input int act, input int exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   for (genvar g = 0; g < 2; g++) begin : g_inst
      localparam int SC = (g == 0) ? 2 : 1;
      logic [2:0] abc;

      lab3_sweep_ctrl #(.SETTLE_CYC(SC)) u_dut (
         .clk   (clk),
         .rst_n (rst_n),
         .bus   (bus[g])
      );

      assign abc          = {bus[g].a, bus[g].b, bus[g].c};
      assign bus[g].start = start_drv[g];
      // lab3 reference: x = carry, y = sum, with injectable faults
      assign bus[g].x     = ((bus[g].a & bus[g].b) | (bus[g].a & bus[g].c) | (bus[g].b & bus[g].c))
                            ^ ((fault_mode[g] == 2) && (abc == 3'd3));
      assign bus[g].y     = (fault_mode[g] == 1) ? 1'b0 : (bus[g].a ^ bus[g].b ^ bus[g].c);
      assign obs_busy[g]  = bus[g].busy;
      assign obs_pass[g]  = bus[g].pass;

      always @(negedge clk) begin
         exp_t e;
         if (!rst_n) begin
            busy_cnt[g] = 0;
         end else begin
            if (bus[g].busy) begin
               busy_cnt[g]++;
               chk($sformatf("abc_seq%0d", g), int'(abc), (cyc - sweep_start[g]) / (SC + 1));
            end
            if (bus[g].done) begin
               if (sb_q[g].size() == 0) begin
                  chk($sformatf("unexpected_done%0d", g), 1, 0);
               end else begin
                  e = sb_q[g].pop_front();
                  chk($sformatf("done_cyc%0d", g), cyc, e.done_cyc);
                  chk($sformatf("busy_len%0d", g), busy_cnt[g], e.busy_cyc);
                  chk($sformatf("pass%0d", g), int'(bus[g].pass), int'(e.pass));
                  chk($sformatf("fail_count%0d", g), int'(bus[g].fail_count), int'(e.fc));
                  chk($sformatf("ff_valid%0d", g), int'(bus[g].first_fail_valid), int'(e.ffvld));
                  if (e.ffvld)
                     chk($sformatf("ff_vec%0d", g), int'(bus[g].first_fail_vec), int'(e.ffvec));
                  chk($sformatf("abc_end%0d", g), int'(abc), int'(e.abc));
               end
               busy_cnt[g] = 0;
            end
         end
      end
   end

   function automatic exp_t mk(int d, int bc, logic p, logic [3:0] fc, logic v, logic [2:0] fv,
                               logic [2:0] abc);
      exp_t e;
      e.done_cyc = d;
      e.busy_cyc = bc;
      e.pass     = p;
      e.fc       = fc;
      e.ffvld    = v;
      e.ffvec    = fv;
      e.abc      = abc;
      return e;
   endfunction

   // Pulse start on instance g; returns at the negedge following the accepting edge.
   task automatic issue(input int g, input int fault, input exp_t e, input bit push);
      @(negedge clk);
      fault_mode[g]  = fault;
      sweep_start[g] = cyc + 1;
      e.done_cyc     = e.done_cyc + cyc + 1;
      if (push) sb_q[g].push_back(e);
      start_drv[g] = 1'b1;
      @(negedge clk);
      start_drv[g] = 1'b0;
      chk($sformatf("busy_after_start%0d", g), int'(obs_busy[g]), 1);
      chk($sformatf("pass_cleared%0d", g), int'(obs_pass[g]), 0);
   endtask

   task automatic wait_drain(input int g);
      int n;
      n = 0;
      while (sb_q[g].size() != 0 && n < 200) begin
         @(negedge clk);
         n++;
      end
      chk($sformatf("drain_timeout%0d", g), int'(sb_q[g].size()), 0);
   endtask

   task automatic pulse_start(input int g);
      start_drv[g] = 1'b1;
      @(negedge clk);
      start_drv[g] = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      tests          = 0;
      fails          = 0;
      cyc            = 0;
      rst_n          = 1'b0;
      start_drv[0]   = 1'b0;
      start_drv[1]   = 1'b0;
      fault_mode[0]  = 0;
      fault_mode[1]  = 0;
      sweep_start[0] = 0;
      sweep_start[1] = 0;
      busy_cnt[0]    = 0;
      busy_cnt[1]    = 0;
      repeat (3) @(negedge clk);

      chk("rst_busy", int'(bus[0].busy), 0);
      chk("rst_done", int'(bus[0].done), 0);
      chk("rst_pass", int'(bus[0].pass), 0);
      chk("rst_abc", int'({bus[0].a, bus[0].b, bus[0].c}), 0);
      chk("rst_fail_count", int'(bus[0].fail_count), 0);
      chk("rst_ff_vec", int'(bus[0].first_fail_vec), 0);
      chk("rst_ff_valid", int'(bus[0].first_fail_valid), 0);
      rst_n = 1'b1;

      // correct full adder
      issue(0, 0, mk(24, 24, 1'b1, 4'd0, 1'b0, 3'd0, 3'd7), 1'b1);
      wait_drain(0);
      repeat (5) @(negedge clk);
      chk("pass_held", int'(bus[0].pass), 1);

      // y stuck at 0: vectors 1,2,4,7 mismatch
`ifdef SWEEP_STOP_ON_FAIL_EN
      issue(0, 1, mk(6, 6, 1'b0, 4'd1, 1'b1, 3'd1, 3'd1), 1'b1);
`else
      issue(0, 1, mk(24, 24, 1'b0, 4'd4, 1'b1, 3'd1, 3'd7), 1'b1);
`endif
      wait_drain(0);

      // start re-pulsed mid-sweep must be ignored
      issue(0, 0, mk(24, 24, 1'b1, 4'd0, 1'b0, 3'd0, 3'd7), 1'b1);
      repeat (4) @(negedge clk);
      pulse_start(0);
      repeat (14) @(negedge clk);
      pulse_start(0);
      wait_drain(0);
      repeat (30) @(negedge clk);

      // reset mid-sweep
      issue(0, 0, mk(24, 24, 1'b1, 4'd0, 1'b0, 3'd0, 3'd7), 1'b0);
      repeat (10) @(negedge clk);
      rst_n = 1'b0;
      #1;
      chk("arst_busy", int'(bus[0].busy), 0);
      chk("arst_abc", int'({bus[0].a, bus[0].b, bus[0].c}), 0);
      chk("arst_fail_count", int'(bus[0].fail_count), 0);
      chk("arst_done", int'(bus[0].done), 0);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (30) @(negedge clk);
      chk("no_busy_after_rst", int'(bus[0].busy), 0);
      issue(0, 0, mk(24, 24, 1'b1, 4'd0, 1'b0, 3'd0, 3'd7), 1'b1);
      wait_drain(0);

      // x inverted at vector 3
`ifdef SWEEP_STOP_ON_FAIL_EN
      issue(0, 2, mk(12, 12, 1'b0, 4'd1, 1'b1, 3'd3, 3'd3), 1'b1);
`else
      issue(0, 2, mk(24, 24, 1'b0, 4'd1, 1'b1, 3'd3, 3'd7), 1'b1);
`endif
      wait_drain(0);

      // SETTLE_CYC=1 instance
      issue(1, 0, mk(16, 16, 1'b1, 4'd0, 1'b0, 3'd0, 3'd7), 1'b1);
      wait_drain(1);

      repeat (10) @(negedge clk);
      chk("sb_empty0", sb_q[0].size(), 0);
      chk("sb_empty1", sb_q[1].size(), 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
